nkmm_prog_loader: RTL and testbench

- Boot/reload controller for the nkmm CPU program memory.
- Holds the CPU in reset, receives a byte stream from the host, and packs it into instruction words.
- Writes those words into program memory from address 0, then releases the CPU after a fixed reset-hold interval.
- Sits between the host link, the pmem write port and the rst input of nkmm_cpu.

---
 rtl/nkmm_const.sv | 14 +
 rtl/nkmm_byte_packer.sv | 38 +++
 rtl/nkmm_prog_loader.sv | 132 +++++++++++++
 tb/tb_nkmm_prog_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nkmm_const.sv
// Shared nkmm constants and program-loader state encodings.
// Loader state is a 3-bit enum so it can be probed directly on debug buses.
package nkmm_const;
  localparam int INSN_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    LDR_HOLD    = 3'd0,
    LDR_RECV    = 3'd1,
    LDR_WRITE   = 3'd2,
    LDR_RELEASE = 3'd3,
    LDR_RUN     = 3'd4
  } ldr_state_t;
endpackage

// File: rtl/nkmm_byte_packer.sv
// Packs accepted bytes little-endian into an instruction word; o_word_vld is combinational
// with the final byte and o_word_dat already includes it. No backpressure: the caller gates i_byte_vld.
module nkmm_byte_packer #(
  parameter int INSN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_byte_vld,
  input  logic [7:0]            i_byte_dat,
  output logic                  o_word_vld,
  output logic [INSN_WIDTH-1:0] o_word_dat
);
  localparam int NB = INSN_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic [INSN_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_cnt;
  logic [INSN_WIDTH-1:0] w_shift_nxt;

  // New bytes enter at the top, so after NB shifts byte 0 sits in bits [7:0].
  assign w_shift_nxt = {i_byte_dat, r_shift[INSN_WIDTH-1:8]};
  assign o_word_vld  = i_byte_vld && (r_cnt == BW'(NB - 1));
  assign o_word_dat  = w_shift_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_vld) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= o_word_vld ? '0 : r_cnt + BW'(1);
    end
  end
endmodule

// File: rtl/nkmm_prog_loader.sv
// Boot/reload controller: holds nkmm_cpu in reset, packs host bytes into pmem words from address 0.
// Last byte at N -> pm_we_o at N+1 -> release/done at N+2+RESET_HOLD; s_ready_o drops outside RECV.
module nkmm_prog_loader #(
  parameter int INSN_WIDTH = nkmm_const::INSN_WIDTH,
  parameter int ADDR_WIDTH = nkmm_const::ADDR_WIDTH,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] pm_addr_o,
  output logic [INSN_WIDTH-1:0] pm_data_o,
  output logic                  pm_we_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  import nkmm_const::*;

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  ldr_state_t            r_state, w_next;
  logic [ADDR_WIDTH:0]   r_word_cnt, r_len, w_word_cnt_inc;
  logic [HW-1:0]         r_hold_cnt;
  logic [ADDR_WIDTH-1:0] r_pm_addr;
  logic [INSN_WIDTH-1:0] r_pm_data;
  logic                  r_done, r_err;
  logic                  w_len_ok, w_can_start, w_start_ok, w_start_bad, w_abort;
  logic                  w_word_vld;
  logic [INSN_WIDTH-1:0] w_word;

  assign w_len_ok       = (load_len_i != '0) && (load_len_i <= MAX_LEN);
  assign w_can_start    = (r_state == LDR_HOLD) || (r_state == LDR_RUN);
  assign w_start_ok     = load_start_i && w_can_start && w_len_ok;
  assign w_start_bad    = load_start_i && w_can_start && !w_len_ok;
  assign w_abort        = abort_i && ((r_state == LDR_RECV) || (r_state == LDR_WRITE));
  assign w_word_cnt_inc = r_word_cnt + (ADDR_WIDTH + 1)'(1);

  nkmm_byte_packer #(.INSN_WIDTH(INSN_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_ok),
    .i_byte_vld (s_valid_i && s_ready_o),
    .i_byte_dat (s_data_i),
    .o_word_vld (w_word_vld),
    .o_word_dat (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= LDR_HOLD;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    s_ready_o = 1'b0;
    busy_o    = 1'b0;
    cpu_rst_o = 1'b1;
    pm_we_o   = 1'b0;
    case (r_state)
      LDR_HOLD: begin
        if (w_start_ok) w_next = LDR_RECV;
      end
      LDR_RECV: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (abort_i)         w_next = LDR_HOLD;
        else if (w_word_vld) w_next = LDR_WRITE;
      end
      LDR_WRITE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          w_next = LDR_HOLD;
        end else begin
          pm_we_o = 1'b1;
          w_next  = (w_word_cnt_inc == r_len) ? LDR_RELEASE : LDR_RECV;
        end
      end
      LDR_RELEASE: begin
        busy_o = 1'b1;
        if (r_hold_cnt == HW'(RESET_HOLD - 1)) w_next = LDR_RUN;
      end
      LDR_RUN: begin
        cpu_rst_o = 1'b0;
        if (w_start_ok)       w_next = LDR_RECV;
        else if (w_start_bad) w_next = LDR_HOLD;
      end
      default: w_next = LDR_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_cnt <= '0;
      r_len      <= '0;
      r_hold_cnt <= '0;
      r_pm_addr  <= '0;
      r_pm_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= (r_state == LDR_RELEASE) && (w_next == LDR_RUN);
      if (w_start_ok) begin
        r_err      <= 1'b0;
        r_len      <= load_len_i;
        r_word_cnt <= '0;
      end else if (w_start_bad || w_abort) begin
        r_err <= 1'b1;
      end
      // Address/data are captured on entry to WRITE and held until the next word.
      if ((r_state == LDR_RECV) && w_word_vld && !abort_i) begin
        r_pm_addr <= r_word_cnt[ADDR_WIDTH-1:0];
        r_pm_data <= w_word;
      end
      if ((r_state == LDR_WRITE) && !abort_i) r_word_cnt <= w_word_cnt_inc;
      if (r_state == LDR_RELEASE) r_hold_cnt <= r_hold_cnt + HW'(1);
      else                        r_hold_cnt <= '0;
    end
  end

  assign pm_addr_o = r_pm_addr;
  assign pm_data_o = r_pm_data;
  assign done_o    = r_done;
  assign err_o     = r_err;
endmodule

// File: tb/tb_nkmm_prog_loader.sv
// Scoreboard bench for nkmm_prog_loader: expected pmem writes are queued as bytes are driven
// and popped by a negedge monitor whenever pm_we_o is seen.
module tb_nkmm_prog_loader;
  localparam int AW = 10;
  localparam int IW = 32;
  localparam int RH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          load_start_i = 1'b0;
  logic [AW:0]   load_len_i = '0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] pm_addr_o;
  logic [IW-1:0] pm_data_o;
  logic          pm_we_o, cpu_rst_o, busy_o, done_o, err_o;

  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  nkmm_prog_loader #(.INSN_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_HOLD(RH)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .load_start_i(load_start_i), .load_len_i(load_len_i), .abort_i(abort_i),
    .pm_addr_o(pm_addr_o), .pm_data_o(pm_data_o), .pm_we_o(pm_we_o),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pm_we_o === 1'b1) begin
      n_wr++;
      chk("rdy_in_write", 64'(s_ready_o), 64'd0);
      if (exp_q.size() == 0) begin
        chk("pm_unexpected", 64'(n_wr), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pm_addr", 64'(pm_addr_o), 64'(mon_e[AW+IW-1:IW]));
        chk("pm_data", 64'(pm_data_o), 64'(mon_e[IW-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start_i = 1'b1;
    load_len_i   = len[AW:0];
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    s_data_i  = b;
    s_valid_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready_o;
      tick();
    end
    if (!acc) chk("byte_timeout", 64'd0, 64'd1);
    if (gap) begin
      s_valid_i = 1'b0;
      tick();
    end
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input bit gap, input bit push);
    if (push) exp_q.push_back({addr[AW-1:0], w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  // exp_lat: negedges from now until the first RUN cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int  k     = 0;
    int  early = 0;
    bit  seen  = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        k    = i;
      end else if (!cpu_rst_o) begin
        early++;
      end
    end
    chk({tag, "_done_lat"}, 64'(k), 64'(exp_lat));
    chk({tag, "_cpu_rst_at_done"}, 64'(cpu_rst_o), 64'd0);
    chk({tag, "_cpu_rst_early"}, 64'(early), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    chk({tag, "_run_cpu_rst"}, 64'(cpu_rst_o), 64'd0);
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cpu_rst", 64'(cpu_rst_o), 64'd1);
    chk("rst_ready", 64'(s_ready_o), 64'd0);
    chk("rst_we", 64'(pm_we_o), 64'd0);
    chk("rst_addr", 64'(pm_addr_o), 64'd0);
    chk("rst_data", 64'(pm_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst = 1'b1;
    tick();

    // Back-to-back two-word load.
    start_load(2);
    @(negedge clk);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_ready", 64'(s_ready_o), 64'd1);
    chk("t1_cpu_rst", 64'(cpu_rst_o), 64'd1);
    tick();
    send_word(0, 32'h44332211, 1'b0, 1'b1);
    send_word(1, 32'h88776655, 1'b0, 1'b1);
    s_valid_i = 1'b0;
    wait_done("t1", 2 + RH);
    chk("t1_nwr", 64'(n_wr), 64'd2);

    // Same load from RUN with valid toggling.
    start_load(2);
    @(negedge clk);
    chk("t2_cpu_rst", 64'(cpu_rst_o), 64'd1);
    tick();
    send_word(0, 32'h44332211, 1'b1, 1'b1);
    send_word(1, 32'h88776655, 1'b1, 1'b1);
    wait_done("t2", 1 + RH);
    chk("t2_nwr", 64'(n_wr), 64'd4);

    // Reload with one word from RUN.
    start_load(1);
    @(negedge clk);
    chk("t3_cpu_rst", 64'(cpu_rst_o), 64'd1);
    tick();
    send_word(0, 32'hDEADBEEF, 1'b0, 1'b1);
    s_valid_i = 1'b0;
    wait_done("t3", 2 + RH);
    chk("t3_nwr", 64'(n_wr), 64'd5);

    // Abort after 5 of 8 bytes.
    start_load(2);
    send_word(0, 32'hA4A3A2A1, 1'b0, 1'b1);
    send_byte(8'hB1, 1'b0);
    s_valid_i = 1'b0;
    abort_i   = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    chk("t4_err", 64'(err_o), 64'd1);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_cpu_rst", 64'(cpu_rst_o), 64'd1);
    chk("t4_ready", 64'(s_ready_o), 64'd0);
    repeat (8) tick();
    chk("t4_nwr", 64'(n_wr), 64'd6);
    start_load(1);
    @(negedge clk);
    chk("t4_err_clr", 64'(err_o), 64'd0);
    tick();
    send_word(0, 32'h0BADCAFE, 1'b0, 1'b1);
    s_valid_i = 1'b0;
    wait_done("t4b", 2 + RH);
    chk("t4b_nwr", 64'(n_wr), 64'd7);

    // Abort landing in the WRITE cycle suppresses the write.
    start_load(1);
    send_word(0, 32'h12345678, 1'b0, 1'b0);
    s_valid_i = 1'b0;
    abort_i   = 1'b1;
    @(negedge clk);
    chk("t5_we_supp", 64'(pm_we_o), 64'd0);
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    chk("t5_err", 64'(err_o), 64'd1);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_cpu_rst", 64'(cpu_rst_o), 64'd1);
    tick();
    chk("t5_nwr", 64'(n_wr), 64'd7);

    // Zero and oversize lengths.
    pulse_rst();
    chk("t6_err_after_rst", 64'(err_o), 64'd0);
    start_load(0);
    @(negedge clk);
    chk("t6_len0_err", 64'(err_o), 64'd1);
    chk("t6_len0_busy", 64'(busy_o), 64'd0);
    chk("t6_len0_cpu_rst", 64'(cpu_rst_o), 64'd1);
    tick();
    pulse_rst();
    start_load((1 << AW) + 1);
    @(negedge clk);
    chk("t6_big_err", 64'(err_o), 64'd1);
    chk("t6_big_ready", 64'(s_ready_o), 64'd0);
    chk("t6_big_cpu_rst", 64'(cpu_rst_o), 64'd1);
    repeat (4) tick();
    chk("t6_nwr", 64'(n_wr), 64'd7);

    // Reset mid-RECV discards the partial word.
    start_load(1 << AW);
    @(negedge clk);
    chk("t7_err_clr", 64'(err_o), 64'd0);
    chk("t7_busy", 64'(busy_o), 64'd1);
    tick();
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b0);
    s_valid_i = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t7_rst_busy", 64'(busy_o), 64'd0);
    chk("t7_rst_ready", 64'(s_ready_o), 64'd0);
    chk("t7_rst_cpu_rst", 64'(cpu_rst_o), 64'd1);
    rst = 1'b1;
    tick();
    start_load(1);
    send_word(0, 32'h04030201, 1'b0, 1'b1);
    s_valid_i = 1'b0;
    wait_done("t7", 2 + RH);
    chk("t7_nwr", 64'(n_wr), 64'd8);

    // Full-memory load: counter must reach 2^AW without wrapping.
    start_load(1 << AW);
    for (int a = 0; a < (1 << AW); a++)
      send_word(a, (a * 32'h01010101) ^ 32'h5A5A0000, 1'b0, 1'b1);
    s_valid_i = 1'b0;
    wait_done("t8", 2 + RH);
    chk("t8_nwr", 64'(n_wr), 64'(8 + (1 << AW)));
    chk("t8_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
